// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file widths, the writeback request record and a one-hot helper.
// No ports. Consumers: rf_wb_fifo, rf_wb_arbiter.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NREG       = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    // One-hot mask selecting register a in a per-register bit vector.
    function automatic logic [NREG-1:0] reg_bit(input logic [REG_ADDR_W-1:0] a);
        return NREG'(1) << a;
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: small circular buffer holding mul/div results waiting for the register-file port.
// Ports:
//   clk2      clock, rising edge
//   reset     asynchronous, active-low
//   i_push    write i_din at the tail (caller guarantees not full)
//   i_pop     drop the head entry (caller guarantees not empty)
//   i_din     entry to store {addr, data}
//   o_count   number of stored entries (0..DEPTH)
//   o_head    oldest entry, valid when o_count != 0
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk2,
    input  logic       reset,
    input  logic       i_push,
    input  logic       i_pop,
    input  wb_req_t    i_din,
    output logic [2:0] o_count,
    output wb_req_t    o_head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t       r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [2:0]    r_count;

    // Pointers wrap at DEPTH so non-power-of-two depths work.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= bump(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= bump(r_rd_ptr);
            r_count <= r_count + 3'(i_push) - 3'(i_pop);
        end
    end

    always_ff @(posedge clk2) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between pipeline writeback and buffered mul/div results.
// Ports:
//   clk2, reset                      clock (rising edge), asynchronous active-low reset
//   wb_valid/wb_addr/wb_data         pipeline writeback, never back-pressured; addr 0 means no request
//   md_valid/md_addr/md_data/md_ready mul/div result handshake into the buffer
//   md_issue/md_issue_addr           mul/div issue, marks the destination pending
//   rd_addr1/rd_addr2                decode-stage source registers
//   hazard_stall                     a decode source or the issue destination is still pending
//   wb_hold                          one-cycle request to suppress wb_valid so the buffer can drain
//   rf_we/rf_waddr/rf_wdata          registered register-file write port
// Build option: define RF_WB_SCOREBOARD_EN to include the pending-register scoreboard;
// otherwise hazard_stall is 0 and the issue/decode inputs are ignored.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk2,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  md_valid,
    input  logic [REG_ADDR_W-1:0] md_addr,
    input  logic [DATA_W-1:0]     md_data,
    output logic                  md_ready,
    input  logic                  md_issue,
    input  logic [REG_ADDR_W-1:0] md_issue_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr1,
    input  logic [REG_ADDR_W-1:0] rd_addr2,
    output logic                  hazard_stall,
    output logic                  wb_hold,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata
);

    localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [2:0]    w_count;
    wb_req_t       w_head;
    wb_req_t       w_win;
    logic          w_wb_win;
    logic          w_nonempty;
    logic          w_push;
    logic          w_pop;
    logic          w_md_write;
    logic          w_starve_inc;
    logic          w_starve_hit;
    logic [SW-1:0] r_starve;
    logic          r_hold;
    logic          r_we;
    wb_req_t       r_wr;

    assign w_wb_win   = wb_valid && (wb_addr != '0);
    assign w_nonempty = (w_count != 3'd0);
    // md_ready looks only at the registered count, so a full buffer refuses even if it pops this cycle.
    assign md_ready   = (w_count < 3'(BUF_DEPTH));
    assign w_push     = md_valid && md_ready;
    assign w_pop      = !w_wb_win && w_nonempty;
    // Address-0 entries are popped but never reach the register file.
    assign w_md_write = w_pop && (w_head.addr != '0);
    assign w_win      = w_wb_win ? '{addr: wb_addr, data: wb_data} : w_head;

    rf_wb_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk2    (clk2),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   ('{addr: md_addr, data: md_data}),
        .o_count (w_count),
        .o_head  (w_head)
    );

    // Counts cycles the buffer waited behind wb; the hit cycle raises wb_hold and restarts the count.
    assign w_starve_inc = w_nonempty && w_wb_win;
    assign w_starve_hit = w_starve_inc && (r_starve == SW'(STARVE_LIMIT - 1));

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            r_starve <= '0;
            r_hold   <= 1'b0;
        end else begin
            r_hold   <= w_starve_hit;
            r_starve <= (w_pop || w_starve_hit) ? '0 : (w_starve_inc ? r_starve + SW'(1) : r_starve);
        end
    end

    // Address and data only move on a real write; otherwise they keep the last written values.
    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            r_we <= 1'b0;
            r_wr <= '0;
        end else begin
            r_we <= w_wb_win || w_md_write;
            if (w_wb_win || w_md_write) r_wr <= w_win;
        end
    end

    assign wb_hold  = r_hold;
    assign rf_we    = r_we;
    assign rf_waddr = r_wr.addr;
    assign rf_wdata = r_wr.data;

`ifdef RF_WB_SCOREBOARD_EN
    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;

    assign w_set = (md_issue && (md_issue_addr != '0)) ? reg_bit(md_issue_addr) : '0;
    assign w_clr = w_md_write ? reg_bit(w_head.addr) : '0;

    // Set is applied after clear so a same-cycle reissue keeps the register pending; bit 0 stays clear.
    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) r_pending <= '0;
        else        r_pending <= ((r_pending & ~w_clr) | w_set) & ~NREG'(1);
    end

    assign hazard_stall = r_pending[rd_addr1] | r_pending[rd_addr2] | (md_issue & r_pending[md_issue_addr]);
`else
    logic w_unused;
    assign w_unused     = ^{md_issue, md_issue_addr, rd_addr1, rd_addr2};
    assign hazard_stall = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scoreboard bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

`ifdef RF_WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic        clk2 = 1'b0;
    logic        reset = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        md_valid = 1'b0;
    logic [4:0]  md_addr = '0;
    logic [31:0] md_data = '0;
    logic        md_ready;
    logic        md_issue = 1'b0;
    logic [4:0]  md_issue_addr = '0;
    logic [4:0]  rd_addr1 = '0;
    logic [4:0]  rd_addr2 = '0;
    logic        hazard_stall;
    logic        wb_hold;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int total = 0;
    int bad = 0;
    wb_req_t exp_q[$];

    rf_wb_arbiter #(.BUF_DEPTH(2), .STARVE_LIMIT(3)) dut (
        .clk2(clk2), .reset(reset),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
        .md_issue(md_issue), .md_issue_addr(md_issue_addr),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .hazard_stall(hazard_stall), .wb_hold(wb_hold),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk2 = ~clk2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic tick;
        @(posedge clk2);
        #1;
    endtask

    // Monitor: every register-file write must match the next expected write in order.
    always @(negedge clk2) begin
        if (rf_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got r%0d=0x%0h expected no write", rf_waddr, rf_wdata);
            end else begin
                wb_req_t e;
                e = exp_q.pop_front();
                if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
                    bad++;
                    $display("FAIL write: got r%0d=0x%0h expected r%0d=0x%0h", rf_waddr, rf_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        // Reset state
        tick; tick;
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_hold", wb_hold, 0);
        reset = 1'b1;
        #1 chk("rst_ready", md_ready, 1);
        tick;

        // Simple writeback, latency 1
        wb_valid = 1; wb_addr = 5; wb_data = 32'h11; expect_wr(5, 32'h11);
        tick;
        wb_valid = 0;
        tick;

        // md push concurrent with wb: wb first, md next cycle
        wb_valid = 1; wb_addr = 3; wb_data = 32'hBB; expect_wr(3, 32'hBB);
        md_valid = 1; md_addr = 7; md_data = 32'hAA; expect_wr(7, 32'hAA);
        tick;
        wb_valid = 0; md_valid = 0;
        tick;
        tick;

        // Starvation: buffer fills behind continuous wb, wb_hold pulses once
        md_valid = 1; md_addr = 7; md_data = 32'hC1;
        wb_valid = 1; wb_addr = 1; wb_data = 32'hD1; expect_wr(1, 32'hD1);
        tick;
        chk("ready_one_entry", md_ready, 1);
        md_addr = 8; md_data = 32'hC2; wb_addr = 2; wb_data = 32'hD2; expect_wr(2, 32'hD2);
        tick;
        chk("ready_full", md_ready, 0);
        chk("hold_early1", wb_hold, 0);
        md_valid = 0; wb_addr = 3; wb_data = 32'hD3; expect_wr(3, 32'hD3);
        tick;
        chk("hold_early2", wb_hold, 0);
        wb_addr = 4; wb_data = 32'hD4; expect_wr(4, 32'hD4);
        tick;
        chk("hold_pulse", wb_hold, 1);
        wb_valid = 0; expect_wr(7, 32'hC1);
        tick;
        chk("hold_one_cycle", wb_hold, 0);
        expect_wr(8, 32'hC2);
        tick;
        chk("ready_drained", md_ready, 1);
        tick;

        // Pending scoreboard on r9
        md_issue = 1; md_issue_addr = 9;
        #1 chk("haz_first_issue", hazard_stall, 0);
        tick;
        md_issue = 0; rd_addr1 = 9;
        #1 chk("haz_rd1", hazard_stall, SB);
        tick;
        rd_addr1 = 0; md_issue = 1; md_issue_addr = 9;
        #1 chk("haz_reissue", hazard_stall, SB);
        tick;
        md_issue = 0; rd_addr1 = 9; md_valid = 1; md_addr = 9; md_data = 32'h99; expect_wr(9, 32'h99);
        #1 chk("haz_push", hazard_stall, SB);
        tick;
        md_valid = 0;
        #1 chk("haz_buffered", hazard_stall, SB);
        tick;
        chk("haz_cleared", hazard_stall, 0);

        // Set wins over clear on r10
        rd_addr1 = 0; md_issue = 1; md_issue_addr = 10;
        tick;
        md_issue = 0; md_valid = 1; md_addr = 10; md_data = 32'hA0; expect_wr(10, 32'hA0);
        tick;
        md_valid = 0; md_issue = 1; md_issue_addr = 10;
        tick;
        md_issue = 0; rd_addr1 = 10;
        #1 chk("haz_set_wins", hazard_stall, SB);
        tick;

        // Address 0 from both sources: no writes, buffer drains, scoreboard untouched
        rd_addr1 = 0; rd_addr2 = 10;
        wb_valid = 1; wb_addr = 0; wb_data = 32'hEE; md_valid = 1; md_addr = 0; md_data = 32'h55;
        tick;
        wb_data = 32'hEF; md_data = 32'h56;
        tick;
        wb_valid = 0; md_valid = 0;
        tick;
        tick;
        chk("zero_we", rf_we, 0);
        chk("zero_waddr_held", rf_waddr, 10);
        chk("zero_wdata_held", rf_wdata, 32'hA0);
        chk("zero_ready", md_ready, 1);
        chk("zero_haz_kept", hazard_stall, SB);
        rd_addr2 = 0;

        // Reset with two buffered entries
        wb_valid = 1; wb_addr = 2; wb_data = 32'hE2; expect_wr(2, 32'hE2);
        md_valid = 1; md_addr = 11; md_data = 32'hB1;
        tick;
        wb_addr = 3; wb_data = 32'hE3; expect_wr(3, 32'hE3);
        md_addr = 12; md_data = 32'hB2;
        tick;
        wb_valid = 0; md_valid = 0;
        chk("pre_rst_full", md_ready, 0);
        @(negedge clk2);
        #1 reset = 1'b0;
        #1 chk("mid_rst_we", rf_we, 0);
        chk("mid_rst_ready", md_ready, 1);
        tick; tick;
        reset = 1'b1; rd_addr1 = 10;
        #1 chk("post_rst_haz", hazard_stall, 0);
        chk("post_rst_waddr", rf_waddr, 0);
        chk("post_rst_hold", wb_hold, 0);
        repeat (4) tick;
        chk("post_rst_ready", md_ready, 1);
        chk("pending_expected", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
